mux_rr_arbiter: RTL
===================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter N, default 4, data width of every requester and of the output.
REQ-002 Parameter STARVE_LIM, default 8, number of lost grants after which a non-urgent requester is promoted to urgent; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 IN_reqValid  input  4  per-requester request valid.
REQ-006 IN_reqUrgent  input  4  per-requester urgent flag; only meaningful while the matching IN_reqValid bit is high.
REQ-007 IN_reqData  input  N x 4 (unpacked [3:0])  per-requester payload.
REQ-008 OUT_reqReady  output  4  one-hot grant / accept, combinational from the current state and inputs.
REQ-009 OUT_valid  output  1  registered output valid.
REQ-010 OUT_data  output  N  registered selected payload.
REQ-011 OUT_src  output  2  index of the requester whose payload is in OUT_data.
REQ-012 IN_ready  input  1  consumer accepts OUT_data when OUT_valid and IN_ready are both high.

Function
REQ-013 The block SHALL compute a slot-free condition: free = !OUT_valid | IN_ready.
REQ-014 When free = 0, OUT_reqReady SHALL be 4'b0000 and no requester state SHALL change.
REQ-015 Effective urgency per requester: eff_urg[i] = IN_reqValid[i] & (IN_reqUrgent[i] | wait_cnt[i] >= STARVE_LIM).
REQ-016 When free = 1 and any eff_urg bit is set, the grant SHALL go to the first set eff_urg bit, searching round-robin from rr_ptr upward modulo 4.
REQ-017 Otherwise, when free = 1, the grant SHALL go to the first set IN_reqValid bit, searching round-robin from rr_ptr upward modulo 4.
REQ-018 The grant index SHALL wrap from 3 to 0.
REQ-019 OUT_reqReady SHALL be one-hot for the granted requester and zero when no requester is valid.
REQ-020 A transfer from requester i SHALL occur when IN_reqValid[i] & OUT_reqReady[i]; requesters hold valid and data until that transfer.
REQ-021 On a transfer from requester g, the next cycle SHALL show OUT_valid = 1, OUT_data = IN_reqData[g] as sampled, and OUT_src = g.
- Latency is 1 cycle from grant to OUT_valid.
- Throughput is 1 transfer per cycle while IN_ready = 1.
REQ-022 When free = 1 and there is no transfer, OUT_valid SHALL go to 0 next cycle, and OUT_data and OUT_src SHALL hold their values.
REQ-023 While OUT_valid = 1 and IN_ready = 0, OUT_valid, OUT_data and OUT_src SHALL remain stable.
REQ-024 On a transfer from requester g, rr_ptr SHALL update to (g+1) mod 4; with no transfer, rr_ptr SHALL hold.
REQ-025 wait_cnt[i] (8-bit, saturating at 255) SHALL update on each transfer:
- cleared when i is granted;
- incremented when IN_reqValid[i] = 1 and a different requester is granted;
- unchanged when there is no transfer;
- cleared when IN_reqValid[i] = 0.
REQ-026 Handshake simultaneity: consumption of the current output (IN_ready = 1) and loading of a new grant in the same cycle SHALL be supported without a bubble.
REQ-027 The priority-select datapath SHALL use at most one level of urgency decode followed by one 4:1 one-hot mux, with no priority chain deeper than 4.

Reset
REQ-028 While rst = 1 at a rising edge, the block SHALL set:
- OUT_valid = 0, OUT_data = 0, OUT_src = 0;
- rr_ptr = 0;
- all wait_cnt = 0.
REQ-029 While rst = 1, OUT_reqReady SHALL be 4'b0000 regardless of other inputs.
REQ-030 A reset asserted mid-operation SHALL discard any held output word; a held word that was never consumed is lost and is not replayed.

Verification
REQ-031 Round-robin fairness: all four valid and non-urgent, IN_ready = 1 constantly, rr_ptr = 0 after reset -> OUT_src sequence 0,1,2,3,0 on consecutive cycles, with OUT_valid high from the cycle after the first grant.
REQ-032 Urgent override: valid = 4'b1111, urgent = 4'b0100, rr_ptr = 0 -> requester 2 is granted, OUT_src = 2 next cycle, rr_ptr = 3.
REQ-033 Backpressure hold: OUT_valid = 1, OUT_data = 5, IN_ready = 0 for 3 cycles with requesters valid -> OUT_reqReady = 0 and OUT_data = 5 held; IN_ready = 1 -> the new grant loads the next cycle with no bubble.
REQ-034 Starvation promotion (STARVE_LIM = 2): requester 0 non-urgent, requester 1 urgent, both continuously valid -> 1 is granted twice, then 0 is granted on the third transfer and wait_cnt[0] clears.
REQ-035 Reset mid-stream: rst pulsed for 1 cycle while OUT_valid = 1 -> next cycle OUT_valid = 0, OUT_data = 0, OUT_src = 0, and the first grant after reset starts its search at requester 0.
REQ-036 Empty/idle: valid = 0 for 4 cycles with IN_ready = 1 -> OUT_valid = 0, OUT_reqReady = 0, and rr_ptr unchanged.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Request/response bundle for mux_rr_arbiter: four requesters with valid,
// urgent flag and payload, plus a single registered output channel.
interface mux_rr_arbiter_if #(
    parameter int N = 4
);
    logic [3:0]   IN_reqValid;
    logic [3:0]   IN_reqUrgent;
    logic [N-1:0] IN_reqData [3:0];
    logic [3:0]   OUT_reqReady;
    logic         OUT_valid;
    logic [N-1:0] OUT_data;
    logic [1:0]   OUT_src;
    logic         IN_ready;

    // Arbiter side
    modport slave (
        input  IN_reqValid,
        input  IN_reqUrgent,
        input  IN_reqData,
        input  IN_ready,
        output OUT_reqReady,
        output OUT_valid,
        output OUT_data,
        output OUT_src
    );

    // Environment side: requesters and output consumer
    modport master (
        output IN_reqValid,
        output IN_reqUrgent,
        output IN_reqData,
        output IN_ready,
        input  OUT_reqReady,
        input  OUT_valid,
        input  OUT_data,
        input  OUT_src
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter/mux with urgent override and starvation
// promotion, feeding a single registered output slot.
module mux_rr_arbiter #(
    parameter int N          = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux_rr_arbiter_if.slave bus
);

    logic [7:0]   r_wait [4];
    logic [1:0]   r_rr_ptr;
    logic         r_valid;
    logic [N-1:0] r_data;
    logic [1:0]   r_src;

    logic         w_free;
    logic [3:0]   w_eff_urg;
    logic [3:0]   w_cand;
    logic         w_gnt_any;
    logic [1:0]   w_gnt_idx;
    logic [3:0]   w_grant;
    logic         w_xfer;
    logic [N-1:0] w_mux_data;

    // Output slot can take a new word when empty or being drained this cycle
    assign w_free = !r_valid | bus.IN_ready;

    // Urgency: explicit flag, or promoted after too many lost grants
    always_comb begin
        w_eff_urg = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_eff_urg[i] = bus.IN_reqValid[i] &
                           (bus.IN_reqUrgent[i] | (r_wait[i] >= 8'(STARVE_LIM)));
        end
    end

    // Urgent requesters win outright; otherwise any valid requester competes
    assign w_cand = (|w_eff_urg) ? w_eff_urg : bus.IN_reqValid;

    // Round-robin search from r_rr_ptr; walking offsets downward lets the
    // nearest candidate overwrite farther ones
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = r_rr_ptr;
        for (int unsigned k = 4; k > 0; k--) begin
            if (w_cand[r_rr_ptr + 2'(k - 1)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = r_rr_ptr + 2'(k - 1);
            end
        end
    end

    assign w_grant = (rst || !w_free || !w_gnt_any) ? 4'b0000 : (4'b0001 << w_gnt_idx);
    assign w_xfer  = |(bus.IN_reqValid & w_grant);

    // One-hot payload mux driven directly by the grant vector
    always_comb begin
        w_mux_data = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_mux_data = w_mux_data | ({N{w_grant[i]}} & bus.IN_reqData[i]);
        end
    end

    // Output slot: load on transfer, drop valid when drained with nothing new
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_free) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_mux_data;
                r_src  <= w_gnt_idx;
            end
        end
    end

    // Pointer and starvation counters advance only on a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_wait[i] <= '0;
            end
        end else if (w_xfer) begin
            r_rr_ptr <= w_gnt_idx + 2'd1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_grant[i] || !bus.IN_reqValid[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != 8'hFF) begin
                    r_wait[i] <= r_wait[i] + 8'd1;
                end
            end
        end
    end

    assign bus.OUT_reqReady = w_grant;
    assign bus.OUT_valid    = r_valid;
    assign bus.OUT_data     = r_data;
    assign bus.OUT_src      = r_src;

endmodule
